core_ctrl: RTL and testbench

Hardware instruction sequencer that produces the 39-bit instruction word consumed by `core`, replacing the testbench-driven instruction stream. On `start` it runs a complete weight-stationary convolution pass for `num_kij` kernel positions: fetch weights into L0, load them into the PE array, stream activations and execute, drain the OFIFO into psum SRAM, then run one SFU readout pass. It sits directly above `core`. Its `inst` output drives `core.inst` and its `ofifo_valid` input comes from `core.ofifo_valid`.

---
 rtl/core_ctrl.sv | 276 +++++++++++++++++++++++++++
 tb/tb_core_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_ctrl.sv
// Instruction sequencer for core: runs a weight-stationary convolution pass over
// num_kij kernel positions, then one SFU readout pass over the psum SRAM.
//
// state  | meaning
// IDLE   | waiting for start, IDLE word on inst
// WFETCH | xmem weight reads, L0 writes trail by one cycle
// WTAIL  | last weight L0 write
// WLOAD  | L0 read into PE array (load)
// WWAIT  | weight settle time
// XFETCH | xmem activation reads, L0 writes trail by one cycle
// XTAIL  | last activation L0 write
// EXEC   | L0 read + execute, OFIFO drained on valid
// DRAIN  | wait until num_nij psums have been written
// SFU    | pmem readout through the SFU
module core_ctrl #(
    parameter int inst_bw = 39,
    parameter int ADDR_W  = 11,
    parameter int row     = 8,
    parameter int col     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W-1:0]  w_base,
    input  logic [ADDR_W-1:0]  x_base,
    input  logic [ADDR_W-1:0]  p_base,
    input  logic [3:0]         num_kij,
    input  logic [ADDR_W-1:0]  num_nij,
    input  logic               cfg_relu,
    input  logic               cfg_simd,
    input  logic               ofifo_valid,
    output logic [inst_bw-1:0] inst,
    output logic               busy,
    output logic               done,
    output logic [3:0]         kij_cnt
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WFETCH,
        S_WTAIL,
        S_WLOAD,
        S_WWAIT,
        S_XFETCH,
        S_XTAIL,
        S_EXEC,
        S_DRAIN,
        S_SFU
    } state_t;

    localparam logic [ADDR_W-1:0] ROW_M1 = ADDR_W'(row - 1);
    localparam logic [ADDR_W-1:0] COL_M1 = ADDR_W'(col - 1);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  rem_q, rem_d;
    logic [ADDR_W-1:0]  w_addr_q, w_addr_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W-1:0]  out_cnt_q, out_cnt_d;
    logic [3:0]         kij_q, kij_d;
    logic               done_q, done_d;
    logic [ADDR_W-1:0]  x_base_q, x_base_d;
    logic [ADDR_W-1:0]  p_base_q, p_base_d;
    logic [ADDR_W-1:0]  num_nij_q, num_nij_d;
    logic [3:0]         num_kij_q, num_kij_d;
    logic               relu_q, relu_d;
    logic               simd_q, simd_d;

    logic [ADDR_W-1:0]  nij_m1;
    logic               drain_fire;

    logic               simd_o, relu_o, sfu_acc_o, acc_o;
    logic               cen_p_o, wen_p_o, cen_x_o, wen_x_o;
    logic [ADDR_W-1:0]  a_p_o, a_x_o;
    logic               ofifo_rd_o, l0_rd_o, l0_wr_o, execute_o, load_o;

    assign nij_m1     = num_nij_q - ADDR_W'(1);
    assign drain_fire = ((state_q == S_EXEC) || (state_q == S_DRAIN)) && ofifo_valid
                        && (out_cnt_q < num_nij_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            rem_q     <= '0;
            w_addr_q  <= '0;
            addr_q    <= '0;
            out_cnt_q <= '0;
            kij_q     <= '0;
            done_q    <= 1'b0;
            x_base_q  <= '0;
            p_base_q  <= '0;
            num_nij_q <= '0;
            num_kij_q <= '0;
            relu_q    <= 1'b0;
            simd_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            w_addr_q  <= w_addr_d;
            addr_q    <= addr_d;
            out_cnt_q <= out_cnt_d;
            kij_q     <= kij_d;
            done_q    <= done_d;
            x_base_q  <= x_base_d;
            p_base_q  <= p_base_d;
            num_nij_q <= num_nij_d;
            num_kij_q <= num_kij_d;
            relu_q    <= relu_d;
            simd_q    <= simd_d;
        end
    end

    // Next state. rem_q counts down the cycles left in the current timed state;
    // w_addr_q is never rewound, so it walks w_base + kij*row + i on its own.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        w_addr_d  = w_addr_q;
        addr_d    = addr_q;
        out_cnt_d = out_cnt_q;
        kij_d     = kij_q;
        done_d    = 1'b0;
        x_base_d  = x_base_q;
        p_base_d  = p_base_q;
        num_nij_d = num_nij_q;
        num_kij_d = num_kij_q;
        relu_d    = relu_q;
        simd_d    = simd_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_WFETCH;
                    rem_d     = ROW_M1;
                    w_addr_d  = w_base;
                    out_cnt_d = '0;
                    kij_d     = '0;
                    x_base_d  = x_base;
                    p_base_d  = p_base;
                    num_nij_d = num_nij;
                    num_kij_d = (num_kij == 4'd0) ? 4'd1 : num_kij;
                    relu_d    = cfg_relu;
                    simd_d    = cfg_simd;
                end
            end
            S_WFETCH: begin
                w_addr_d = w_addr_q + ADDR_W'(1);
                if (rem_q == '0) state_d = S_WTAIL;
                else             rem_d   = rem_q - ADDR_W'(1);
            end
            S_WTAIL: begin
                state_d = S_WLOAD;
                rem_d   = ROW_M1;
            end
            S_WLOAD: begin
                if (rem_q == '0) begin
                    state_d = S_WWAIT;
                    rem_d   = COL_M1;
                end else begin
                    rem_d = rem_q - ADDR_W'(1);
                end
            end
            S_WWAIT: begin
                if (rem_q == '0) begin
                    state_d = S_XFETCH;
                    rem_d   = nij_m1;
                    addr_d  = x_base_q;
                end else begin
                    rem_d = rem_q - ADDR_W'(1);
                end
            end
            S_XFETCH: begin
                addr_d = addr_q + ADDR_W'(1);
                if (rem_q == '0) state_d = S_XTAIL;
                else             rem_d   = rem_q - ADDR_W'(1);
            end
            S_XTAIL: begin
                state_d = S_EXEC;
                rem_d   = nij_m1;
            end
            S_EXEC: begin
                if (drain_fire) out_cnt_d = out_cnt_q + ADDR_W'(1);
                if (rem_q == '0) state_d = S_DRAIN;
                else             rem_d   = rem_q - ADDR_W'(1);
            end
            S_DRAIN: begin
                if (drain_fire) out_cnt_d = out_cnt_q + ADDR_W'(1);
                if (out_cnt_q == num_nij_q) begin
                    if (kij_q == num_kij_q - 4'd1) begin
                        state_d = S_SFU;
                        rem_d   = nij_m1;
                        addr_d  = p_base_q;
                    end else begin
                        state_d   = S_WFETCH;
                        rem_d     = ROW_M1;
                        kij_d     = kij_q + 4'd1;
                        out_cnt_d = '0;
                    end
                end
            end
            S_SFU: begin
                addr_d = addr_q + ADDR_W'(1);
                if (rem_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    rem_d = rem_q - ADDR_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Instruction decode. The drain fields override last since they depend on
    // ofifo_valid in the same cycle.
    always_comb begin
        simd_o     = 1'b0;
        relu_o     = 1'b0;
        sfu_acc_o  = 1'b0;
        acc_o      = 1'b0;
        cen_p_o    = 1'b1;
        wen_p_o    = 1'b1;
        a_p_o      = '0;
        cen_x_o    = 1'b1;
        wen_x_o    = 1'b1;
        a_x_o      = '0;
        ofifo_rd_o = 1'b0;
        l0_rd_o    = 1'b0;
        l0_wr_o    = 1'b0;
        execute_o  = 1'b0;
        load_o     = 1'b0;
        case (state_q)
            S_WFETCH: begin
                cen_x_o = 1'b0;
                a_x_o   = w_addr_q;
                l0_wr_o = (rem_q != ROW_M1);
            end
            S_WTAIL, S_XTAIL: l0_wr_o = 1'b1;
            S_WLOAD: begin
                l0_rd_o = 1'b1;
                load_o  = 1'b1;
            end
            S_XFETCH: begin
                cen_x_o = 1'b0;
                a_x_o   = addr_q;
                l0_wr_o = (rem_q != nij_m1);
            end
            S_EXEC: begin
                l0_rd_o   = 1'b1;
                execute_o = 1'b1;
            end
            S_SFU: begin
                cen_p_o   = 1'b0;
                a_p_o     = addr_q;
                sfu_acc_o = 1'b1;
                relu_o    = relu_q;
                simd_o    = simd_q;
            end
            default: ;
        endcase
        if (drain_fire) begin
            ofifo_rd_o = 1'b1;
            cen_p_o    = 1'b0;
            wen_p_o    = 1'b0;
            a_p_o      = p_base_q + out_cnt_q;
            acc_o      = (kij_q != 4'd0);
        end
    end

    assign inst = {simd_o, relu_o, sfu_acc_o, 1'b0, 1'b0, acc_o, cen_p_o, wen_p_o, a_p_o,
                   cen_x_o, wen_x_o, a_x_o, ofifo_rd_o, 1'b0, 1'b0, l0_rd_o, l0_wr_o,
                   execute_o, load_o};

    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign kij_cnt = kij_q;

endmodule

// File: tb/tb_core_ctrl.sv
// Randomized bench for core_ctrl: records the instruction stream of each pass and
// compares it with event streams derived from the pass configuration.
module tb_core_ctrl;
    localparam int ROW = 8, COL = 8, AW = 11, IW = 39;
    localparam int AMOD = 1 << AW;
    localparam int LIMIT = 8000;
    localparam logic [IW-1:0] IDLE_WORD = 39'h1_800C_0000;

    logic          clk = 1'b0;
    logic          reset, start, cfg_relu, cfg_simd, ofifo_valid;
    logic [AW-1:0] w_base, x_base, p_base, num_nij;
    logic [3:0]    num_kij, kij_cnt;
    logic [IW-1:0] inst;
    logic          busy, done;

    core_ctrl #(.inst_bw(IW), .ADDR_W(AW), .row(ROW), .col(COL)) dut (
        .clk(clk), .reset(reset), .start(start), .w_base(w_base), .x_base(x_base),
        .p_base(p_base), .num_kij(num_kij), .num_nij(num_nij), .cfg_relu(cfg_relu),
        .cfg_simd(cfg_simd), .ofifo_valid(ofifo_valid), .inst(inst), .busy(busy),
        .done(done), .kij_cnt(kij_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    int c_w, c_x, c_p, c_k, c_n, exp_k;
    bit c_relu, c_simd;

    int obs_x[$], obs_pw[$], obs_sfu[$], wstart_q[$], erise_q[$];
    int exp_x[$], exp_pw[$], exp_sfu[$];
    int n_l0wr, n_l0rd, n_load, n_exec, n_bad, n_vdrain;
    int t_first_rd, t_done, t_sfu_first, t_sfu_last;
    int d_x, d_pw, d_sfu, d_tim;
    logic [IW-1:0] done_inst, after_inst;
    logic done_busy, after_done;
    bit timeout;

    // Expected event streams: every xmem read, every psum write (addr|acc|kij) and
    // every SFU read (addr|simd,relu,sfu_acc), in issue order.
    function automatic void build_model();
        exp_k = (c_k == 0) ? 1 : c_k;
        exp_x.delete(); exp_pw.delete(); exp_sfu.delete();
        for (int k = 0; k < exp_k; k++) begin
            for (int i = 0; i < ROW; i++) exp_x.push_back((c_w + k * ROW + i) % AMOD);
            for (int j = 0; j < c_n; j++) exp_x.push_back((c_x + j) % AMOD);
            for (int j = 0; j < c_n; j++)
                exp_pw.push_back(((c_p + j) % AMOD) + ((k != 0) ? 2048 : 0) + (k << 12));
        end
        for (int j = 0; j < c_n; j++)
            exp_sfu.push_back(((c_p + j) % AMOD) +
                              (((c_simd ? 4 : 0) + (c_relu ? 2 : 0) + 1) << 11));
    endfunction

    function automatic int qdiff(input int a[$], input int b[$]);
        int d = 0;
        if (a.size() != b.size()) d++;
        for (int i = 0; i < a.size() && i < b.size(); i++) if (a[i] != b[i]) d++;
        return d;
    endfunction

    // vmode 0: random ofifo_valid; vmode 1: 1,0,1,1,1 from the first EXEC cycle, then held high.
    // junk: scramble config and pulse start while busy.
    task automatic run_pass(input int vmode, input bit junk);
        bit [4:0] pat;
        int nrd, pidx;
        bit exec_seen, prev_exec, fin;
        pat = 5'b11101;
        obs_x.delete(); obs_pw.delete(); obs_sfu.delete(); wstart_q.delete(); erise_q.delete();
        n_l0wr = 0; n_l0rd = 0; n_load = 0; n_exec = 0; n_bad = 0; n_vdrain = 0;
        t_first_rd = -1; t_done = -1; t_sfu_first = -1; t_sfu_last = -1;
        nrd = 0; pidx = 0; exec_seen = 0; prev_exec = 0; fin = 0; timeout = 0;
        for (int t = 0; t < LIMIT && !fin; t++) begin
            @(posedge clk); #1;
            if (t == 0) begin
                start = 1'b1; w_base = AW'(c_w); x_base = AW'(c_x); p_base = AW'(c_p);
                num_kij = 4'(c_k); num_nij = AW'(c_n); cfg_relu = c_relu; cfg_simd = c_simd;
            end else begin
                start = junk && busy && (t % 37 == 5);
                if (junk) begin
                    w_base = AW'($urandom); x_base = AW'($urandom); p_base = AW'($urandom);
                    num_kij = 4'($urandom); num_nij = AW'($urandom_range(1, 50));
                    cfg_relu = 1'($urandom); cfg_simd = 1'($urandom);
                end
            end
            if (inst[1]) exec_seen = 1;
            if (vmode == 1) begin
                ofifo_valid = exec_seen ? ((pidx < 5) ? pat[pidx] : 1'b1) : 1'b0;
                if (exec_seen) pidx++;
            end else begin
                ofifo_valid = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            if (!inst[19]) begin
                if (nrd % (ROW + c_n) == 0) wstart_q.push_back(t);
                if (t_first_rd < 0) t_first_rd = t;
                obs_x.push_back(int'(inst[17:7]));
                nrd++;
            end
            if (inst[2]) n_l0wr++;
            if (inst[3]) n_l0rd++;
            if (inst[0]) n_load++;
            if (inst[1]) n_exec++;
            if (inst[1] && !prev_exec) erise_q.push_back(t);
            prev_exec = inst[1];
            if (!inst[32] && !inst[31])
                obs_pw.push_back(int'(inst[30:20]) + (int'(inst[33]) << 11) + (int'(kij_cnt) << 12));
            if (!inst[32] && inst[31]) begin
                obs_sfu.push_back(int'(inst[30:20]) + (int'(inst[38:36]) << 11));
                if (t_sfu_first < 0) t_sfu_first = t;
                t_sfu_last = t;
            end
            if (inst[35] || inst[34] || inst[5] || inst[4] || !inst[18]) n_bad++;
            if (inst[6] !== (!inst[32] && !inst[31])) n_bad++;
            if (inst[6] && !ofifo_valid) n_bad++;
            if (!busy && inst !== IDLE_WORD) n_bad++;
            if (exec_seen && busy && obs_sfu.size() == 0 && ofifo_valid) n_vdrain++;
            if (done) begin
                t_done = t; done_inst = inst; done_busy = busy; fin = 1;
            end
        end
        start = 1'b0;
        if (!fin) timeout = 1;
        else begin
            @(posedge clk); #1;
            @(negedge clk);
            after_done = done; after_inst = inst;
        end
        d_x = qdiff(obs_x, exp_x);
        d_pw = qdiff(obs_pw, exp_pw);
        d_sfu = qdiff(obs_sfu, exp_sfu);
        d_tim = (erise_q.size() != exp_k || wstart_q.size() != exp_k) ? 1 : 0;
        for (int k = 0; k < erise_q.size() && k < wstart_q.size(); k++)
            if (erise_q[k] - wstart_q[k] != 2 * ROW + COL + c_n + 2) d_tim++;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; ofifo_valid = 1'b1; w_base = '0; x_base = '0;
        p_base = '0; num_kij = 4'd1; num_nij = AW'(1); cfg_relu = 1'b0; cfg_simd = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (inst !== IDLE_WORD || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: inst=%h busy=%b done=%b, want inst=%h busy=0 done=0",
                     inst, busy, done, IDLE_WORD);
        end
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            ofifo_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if (inst !== IDLE_WORD || busy !== 1'b0 || done !== 1'b0 || kij_cnt !== 4'd0) begin
                errors++;
                $display("FAIL reset_release: inst=%h busy=%b done=%b kij=%0d, want %h/0/0/0",
                         inst, busy, done, kij_cnt, IDLE_WORD);
            end
        end
    endtask

    task automatic test_one_kij();
        c_w = 0; c_x = 16; c_p = 100; c_k = 1; c_n = 4; c_relu = 1; c_simd = 1;
        build_model();
        run_pass(1, 0);
        checks++;
        if (timeout) begin errors++; $display("FAIL one_kij_timeout: no done within %0d cycles", LIMIT); end
        checks++;
        if (d_x != 0 || t_first_rd != 1) begin
            errors++;
            $display("FAIL one_kij_xaddr: %0d diffs, first read t=%0d, want 0 diffs t=1", d_x, t_first_rd);
        end
        checks++;
        if (n_l0wr != ROW + c_n || n_l0rd != ROW + c_n || n_load != ROW || n_exec != c_n) begin
            errors++;
            $display("FAIL one_kij_counts: l0_wr=%0d l0_rd=%0d load=%0d exec=%0d, want 12 12 8 4",
                     n_l0wr, n_l0rd, n_load, n_exec);
        end
        checks++;
        if (d_pw != 0 || n_vdrain < 5) begin
            errors++;
            $display("FAIL one_kij_drain: %0d write diffs (%0d writes), valid-high=%0d, want 0 diffs 4 writes >=5",
                     d_pw, obs_pw.size(), n_vdrain);
        end
        checks++;
        if (d_sfu != 0 || t_sfu_last - t_sfu_first + 1 != c_n) begin
            errors++;
            $display("FAIL one_kij_sfu: %0d diffs span=%0d, want 0 diffs span=%0d",
                     d_sfu, t_sfu_last - t_sfu_first + 1, c_n);
        end
        checks++;
        if (d_tim != 0) begin errors++; $display("FAIL one_kij_timing: %0d kij timing errors, want 0", d_tim); end
        checks++;
        if (t_done != t_sfu_last + 1 || done_busy !== 1'b0 || done_inst !== IDLE_WORD) begin
            errors++;
            $display("FAIL one_kij_done: t_done=%0d busy=%b inst=%h, want t=%0d busy=0 inst=%h",
                     t_done, done_busy, done_inst, t_sfu_last + 1, IDLE_WORD);
        end
        checks++;
        if (after_done !== 1'b0 || after_inst !== IDLE_WORD) begin
            errors++;
            $display("FAIL one_kij_after: done=%b inst=%h, want 0 %h", after_done, after_inst, IDLE_WORD);
        end
        checks++;
        if (n_bad != 0) begin errors++; $display("FAIL one_kij_fields: %0d bad cycles, want 0", n_bad); end
    endtask

    task automatic test_multi_kij();
        c_w = $urandom_range(0, 1000); c_x = $urandom_range(0, 2047); c_p = $urandom_range(0, 2047);
        c_k = 3; c_n = 6; c_relu = 0; c_simd = 0;
        build_model();
        run_pass(0, 0);
        checks++;
        if (timeout) begin errors++; $display("FAIL multi_timeout: no done within %0d cycles", LIMIT); end
        checks++;
        if (d_x != 0) begin errors++; $display("FAIL multi_xaddr: %0d diffs of %0d reads, want 0", d_x, obs_x.size()); end
        checks++;
        if (d_pw != 0) begin errors++; $display("FAIL multi_acc: %0d write diffs of %0d writes, want 0", d_pw, obs_pw.size()); end
        checks++;
        if (d_tim != 0) begin errors++; $display("FAIL multi_timing: %0d kij timing errors, want 0", d_tim); end
        checks++;
        if (d_sfu != 0 || n_bad != 0) begin
            errors++;
            $display("FAIL multi_sfu_fields: sfu diffs=%0d bad cycles=%0d, want 0 0", d_sfu, n_bad);
        end
    endtask

    task automatic test_reset_mid();
        bit hit;
        hit = 0;
        @(posedge clk); #1;
        w_base = AW'(300); x_base = AW'(40); p_base = AW'(500); num_kij = 4'd3;
        num_nij = AW'(5); cfg_relu = 1'b0; cfg_simd = 1'b0; ofifo_valid = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int t = 0; t < LIMIT && !hit; t++) begin
            @(posedge clk); #1;
            if (inst[1] && kij_cnt == 4'd1) hit = 1;
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL midreset_reach: EXEC of kij 1 not seen within %0d cycles", LIMIT); end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (inst !== IDLE_WORD || busy !== 1'b0 || done !== 1'b0 || kij_cnt !== 4'd0) begin
            errors++;
            $display("FAIL midreset_idle: inst=%h busy=%b done=%b kij=%0d, want %h/0/0/0",
                     inst, busy, done, kij_cnt, IDLE_WORD);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        c_w = 700; c_x = 9; c_p = 33; c_k = 2; c_n = 3; c_relu = 1; c_simd = 0;
        build_model();
        run_pass(0, 0);
        checks++;
        if (timeout || d_x != 0 || t_first_rd != 1) begin
            errors++;
            $display("FAIL midreset_restart: timeout=%0d xaddr diffs=%0d first=%0d, want 0 0 1",
                     timeout, d_x, t_first_rd);
        end
        checks++;
        if (d_pw != 0 || d_sfu != 0) begin
            errors++;
            $display("FAIL midreset_streams: write diffs=%0d sfu diffs=%0d, want 0 0", d_pw, d_sfu);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            c_k = (it == 0) ? 0 : int'($urandom_range(1, 5));
            c_n = $urandom_range(1, 24);
            c_w = (it == 1) ? AMOD - 3 : int'($urandom_range(0, AMOD - 1));
            c_x = (it == 2) ? AMOD - 2 : int'($urandom_range(0, AMOD - 1));
            c_p = (it == 3) ? AMOD - 1 : int'($urandom_range(0, AMOD - 1));
            c_relu = 1'($urandom); c_simd = 1'($urandom);
            build_model();
            run_pass(0, it != 0);
            checks++;
            if (timeout) begin errors++; $display("FAIL rand%0d_timeout: no done within %0d cycles", it, LIMIT); end
            checks++;
            if (d_x != 0) begin errors++; $display("FAIL rand%0d_xaddr: %0d diffs, want 0", it, d_x); end
            checks++;
            if (d_pw != 0) begin errors++; $display("FAIL rand%0d_writes: %0d diffs, want 0", it, d_pw); end
            checks++;
            if (d_sfu != 0) begin errors++; $display("FAIL rand%0d_sfu: %0d diffs, want 0", it, d_sfu); end
            checks++;
            if (d_tim != 0 || n_load != exp_k * ROW || n_exec != exp_k * c_n || n_l0wr != exp_k * (ROW + c_n)) begin
                errors++;
                $display("FAIL rand%0d_timing: tim=%0d load=%0d exec=%0d l0_wr=%0d, want 0 %0d %0d %0d",
                         it, d_tim, n_load, n_exec, n_l0wr, exp_k * ROW, exp_k * c_n, exp_k * (ROW + c_n));
            end
            checks++;
            if (n_bad != 0 || t_done != t_sfu_last + 1 || after_done !== 1'b0) begin
                errors++;
                $display("FAIL rand%0d_done: bad=%0d t_done=%0d after_done=%b, want 0 %0d 0",
                         it, n_bad, t_done, after_done, t_sfu_last + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_one_kij();
        test_multi_kij();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
